// File: rtl/apb_regbank.sv
// apb_regbank: APB slave register bank for the CRCU control/status store.
// Holds a block of byte-writable RW registers followed by a read-only window
// that reflects hardware status inputs. Each transfer is accepted in setup,
// optionally stretched by a fixed number of wait states, and then completed
// in a single DONE cycle. Errors are reported for misaligned, out-of-range
// or read-only-write accesses.
module apb_regbank #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 32,
    parameter int RO_BASE     = 24,
    parameter int WAIT_STATES = 0
) (
    input  logic                      PCLK,
    input  logic                      PRESETN,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_W-1:0]         PADDR,
    input  logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W/8-1:0]       PSTRB,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [DATA_W-1:0]         PRDATA,
    input  logic [(((DEPTH-RO_BASE) > 0) ? (DEPTH-RO_BASE) : 1)*DATA_W-1:0] ro_in,
    output logic [DEPTH*DATA_W-1:0]   reg_q
);

    localparam int NB  = DATA_W / 8;
    // At least one storage slot so the array stays legal when every index is RO.
    localparam int NRW = (RO_BASE > 0) ? RO_BASE : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [NB-1:0]       r_strb;
    logic [DATA_W-1:0]   r_regs [NRW];

    logic [31:0]         w_idx;
    logic                w_err;
    logic                w_done;
    logic                w_commit;
    logic [DATA_W-1:0]   w_rd;

    // Word index of the captured address, widened for range comparisons.
    assign w_idx    = 32'(r_addr[ADDR_W-1:2]);
    assign w_err    = (r_addr[1:0] != 2'b00)
                   || (w_idx >= 32'(DEPTH))
                   || (r_write && (w_idx >= 32'(RO_BASE)));
    assign w_done   = (r_state == S_DONE);
    // A write lands only if the master is still selecting us at the end of DONE.
    assign w_commit = w_done && PSEL && r_write && !w_err;

    // Transfer sequencer: capture on setup, count wait states, complete in DONE.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_addr  <= PADDR;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_strb  <= PSTRB;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES > 0) ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    if (!PSEL) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RW register file: byte-lane merge of the captured write data on commit.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < NRW; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < RO_BASE; i++) begin
                if (w_idx == 32'(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (r_strb[b]) begin
                            r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux: RW storage below RO_BASE, live status inputs above it.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < RO_BASE; i++) begin
            if (w_idx == 32'(i)) begin
                w_rd = r_regs[i];
            end
        end
        for (int i = RO_BASE; i < DEPTH; i++) begin
            if (w_idx == 32'(i)) begin
                w_rd = ro_in[(i-RO_BASE)*DATA_W +: DATA_W];
            end
        end
    end

    // Bus response is only driven in DONE; error reads return zero.
    always_comb begin
        PREADY  = w_done;
        PSLVERR = w_done && w_err;
        PRDATA  = (w_done && !w_err && !r_write) ? w_rd : '0;
    end

    // Flattened register view for the datapath; RO slots read as zero here.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_regq
            if (gi < RO_BASE) begin : g_rw
                assign reg_q[gi*DATA_W +: DATA_W] = r_regs[gi];
            end else begin : g_ro
                assign reg_q[gi*DATA_W +: DATA_W] = '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_apb_regbank.sv
// tb_apb_regbank: table-driven APB transfers with a scoreboard queue,
// plus hand-written sequences for reset-mid-transfer and PSEL abort.
module tb_apb_regbank;

    localparam int DW      = 32;
    localparam int AW      = 12;
    localparam int DEPTH   = 32;
    localparam int RO_BASE = 24;
    localparam int WS      = 2;
    localparam int NRO     = DEPTH - RO_BASE;
    localparam int NV      = 18;

    logic                 PCLK    = 1'b0;
    logic                 PRESETN = 1'b0;
    logic                 PSEL    = 1'b0;
    logic                 PENABLE = 1'b0;
    logic                 PWRITE  = 1'b0;
    logic [AW-1:0]        PADDR   = '0;
    logic [DW-1:0]        PWDATA  = '0;
    logic [DW/8-1:0]      PSTRB   = '0;
    logic                 PREADY;
    logic                 PSLVERR;
    logic [DW-1:0]        PRDATA;
    logic [NRO*DW-1:0]    ro_in;
    logic [DEPTH*DW-1:0]  reg_q;

    always #5 PCLK = ~PCLK;

    apb_regbank #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH),
        .RO_BASE     (RO_BASE),
        .WAIT_STATES (WS)
    ) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PRDATA  (PRDATA),
        .ro_in   (ro_in),
        .reg_q   (reg_q)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        string         name;
    } vec_t;

    typedef struct {
        logic          is_rd;
        logic [DW-1:0] rd;
        logic          err;
        string         name;
    } exp_t;

    exp_t          sb_q [$];
    vec_t          vecs [NV];
    logic [DW-1:0] m_regs [DEPTH];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic chk_regq(input string name);
        logic [DEPTH*DW-1:0] e;
        int bad;
        bad = -1;
        for (int i = 0; i < DEPTH; i++) begin
            e[i*DW +: DW] = (i < RO_BASE) ? m_regs[i] : '0;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (reg_q[i*DW +: DW] !== e[i*DW +: DW]) bad = i;
        end
        n_checks++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: reg_q[%0d] got 0x%08h required 0x%08h",
                      name, bad, reg_q[bad*DW +: DW], e[bad*DW +: DW]);
    endtask

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [3:0] strb, input logic [DW-1:0] exp_rd,
                            input logic exp_err, input string name);
        exp_t e;
        exp_t g;
        int   cyc;
        bit   done;
        int   idx;
        e.is_rd = !wr;
        e.rd    = exp_rd;
        e.err   = exp_err;
        e.name  = name;
        sb_q.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc <= 20) begin
            @(negedge PCLK);
            if (PREADY) begin
                done = 1'b1;
            end else begin
                @(posedge PCLK); #1;
                cyc++;
            end
        end
        if (done) begin
            g = sb_q.pop_front();
            $display("xfer %-12s %s addr=0x%03h wdata=0x%08h strb=%04b rdata=0x%08h err=%0b cycles=%0d",
                     g.name, wr ? "WR" : "RD", addr, wd, strb, PRDATA, PSLVERR, cyc);
            chk({g.name, " latency"}, 32'(cyc), 32'(WS + 1));
            chk({g.name, " pslverr"}, 32'(PSLVERR), 32'(g.err));
            if (g.is_rd) chk({g.name, " prdata"}, PRDATA, g.rd);
        end else begin
            void'(sb_q.pop_front());
            n_checks++;
            $display("FAIL %s timeout: no PREADY within %0d access cycles, required at cycle %0d",
                     name, cyc - 1, WS + 1);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        if (wr && !exp_err) begin
            idx = int'(addr[AW-1:2]);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) m_regs[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        chk_regq({name, " reg_q"});
    endtask

    initial begin
        int hi_cnt;

        for (int k = 0; k < NRO; k++) begin
            ro_in[k*DW +: DW] = (k == 0) ? 32'hDEAD_BEEF : (32'h1000_0000 + 32'(k));
        end
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;

        //            wr    addr     wdata          strb    exp_rd         err   name
        vecs[0]  = '{1'b1, 12'h008, 32'hA5A5_1234, 4'hF, 32'h0000_0000, 1'b0, "wr_full"};
        vecs[1]  = '{1'b0, 12'h008, 32'h0,         4'h0, 32'hA5A5_1234, 1'b0, "rd_full"};
        vecs[2]  = '{1'b1, 12'h008, 32'hFFFF_FFFF, 4'h5, 32'h0000_0000, 1'b0, "wr_strb0101"};
        vecs[3]  = '{1'b0, 12'h008, 32'h0,         4'h0, 32'hA5FF_12FF, 1'b0, "rd_strb0101"};
        vecs[4]  = '{1'b1, 12'h080, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1, "wr_oor"};
        vecs[5]  = '{1'b0, 12'h080, 32'h0,         4'h0, 32'h0000_0000, 1'b1, "rd_oor"};
        vecs[6]  = '{1'b1, 12'h00A, 32'h0000_5555, 4'hF, 32'h0000_0000, 1'b1, "wr_misalign"};
        vecs[7]  = '{1'b0, 12'h00A, 32'h0,         4'h0, 32'h0000_0000, 1'b1, "rd_misalign"};
        vecs[8]  = '{1'b0, 12'h060, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, "rd_ro0"};
        vecs[9]  = '{1'b1, 12'h060, 32'h0,         4'hF, 32'h0000_0000, 1'b1, "wr_ro0"};
        vecs[10] = '{1'b0, 12'h060, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, "rd_ro0_again"};
        vecs[11] = '{1'b1, 12'h05C, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0, "wr_last_rw"};
        vecs[12] = '{1'b0, 12'h05C, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, "rd_last_rw"};
        vecs[13] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0, "wr_nostrb"};
        vecs[14] = '{1'b0, 12'h000, 32'h0,         4'h0, 32'h0000_0000, 1'b0, "rd_nostrb"};
        vecs[15] = '{1'b0, 12'h07C, 32'h0,         4'h0, 32'h1000_0007, 1'b0, "rd_ro_last"};
        vecs[16] = '{1'b1, 12'h004, 32'h1122_3344, 4'h8, 32'h0000_0000, 1'b0, "wr_strb1000"};
        vecs[17] = '{1'b0, 12'h004, 32'h0,         4'h0, 32'h1100_0000, 1'b0, "rd_strb1000"};

        // Reset state
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset pready",  32'(PREADY),  32'h0);
        chk("reset pslverr", 32'(PSLVERR), 32'h0);
        chk("reset prdata",  PRDATA,       32'h0);
        chk_regq("reset reg_q");
        @(posedge PCLK); #1;
        PRESETN = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                     vecs[i].exp_rd, vecs[i].exp_err, vecs[i].name);
        end

        // PSEL dropped during wait states: no completion, no write
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h00C; PWDATA = 32'h0000_00AB; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        hi_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge PCLK);
            if (PREADY) hi_cnt++;
        end
        $display("xfer %-12s WR addr=0x00c aborted pready_high_cycles=%0d", "abort_wait", hi_cnt);
        chk("abort pready_cycles", 32'(hi_cnt), 32'h0);
        chk_regq("abort reg_q");
        apb_xfer(1'b0, 12'h00C, 32'h0,         4'h0, 32'h0000_0000, 1'b0, "rd_after_abt");
        apb_xfer(1'b1, 12'h00C, 32'h0BAD_CAFE, 4'hF, 32'h0000_0000, 1'b0, "wr_after_abt");
        apb_xfer(1'b0, 12'h00C, 32'h0,         4'h0, 32'h0BAD_CAFE, 1'b0, "rd_after_wr");

        // Reset asserted mid-WAIT: clears everything at once, write never lands
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h010; PWDATA = 32'h0000_0077; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETN = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        $display("xfer %-12s WR addr=0x010 reset asserted mid-wait", "reset_wait");
        chk("rstwait pready", 32'(PREADY), 32'h0);
        chk_regq("rstwait reg_q");
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETN = 1'b1;
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 32'h0000_0000, 1'b0, "rd_after_rst");
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 32'h0000_0000, 1'b0, "rd_cleared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
